log2_pipe: RTL and testbench
============================

Name: log2_pipe

Overview:
- Pipelined, parametrised fixed-point base-2 logarithm unit; successor to the combinational `log2` block.
- Adds valid/ready streaming, a selectable output base (log2, ln, log10) and a segment-LUT correction on top of the Mitchell approximation.
- Sits in the nonlinear-function datapath; downstream consumers (softmax, norm) apply back-pressure.

Parameters:
- IN_WIDTH, 16, unsigned input width.
- FRAC_IN, 8, fractional bits of input (Bf).
- OUT_WIDTH, 16, signed output width.
- FRAC_OUT, 8, fractional bits of output.
- SEG_BITS, 3, log2 of correction-LUT segment count.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-low reset.
- in_valid  in  1  input beat valid.
- in_ready  out  1  unit accepts beat this cycle.
- in_data  in  IN_WIDTH  unsigned Q(IN_WIDTH-FRAC_IN).FRAC_IN operand.
- in_mode  in  2  0=log2, 1=ln, 2=log10, 3=reserved (treated as 0).
- out_valid  out  1  result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  OUT_WIDTH  signed Q.FRAC_OUT result.
- out_zero  out  1  operand was zero; out_data is saturated.

Behaviour:
- Reset (rst=0, async): all stage valids, out_valid, out_zero and out_data are 0. Reset mid-operation discards every in-flight beat. No output valid until first accepted beat + 4 cycles.
- Global stall enable `en = ~out_valid | out_ready`; in_ready = en. All stage registers advance only when en=1, so no bubble is collapsed and the whole pipe freezes under back-pressure. out_data and out_zero hold stable while out_valid=1 and out_ready=0.
- Latency: exactly 4 clk from accept (in_valid & in_ready) to out_valid when unstalled. Throughput: 1 beat/cycle.
- S1: leading-one detector on in_data produces position p. exp = p - FRAC_IN (signed). zero = (in_data==0). Captures mode.
- S2: normalise with a left barrel shift so the leading one is dropped. Frac f = the top FRAC_OUT bits below the leading one, zero-padded, truncated, never rounded.
- S3: seg = top SEG_BITS of f. corr = LUT[seg], where LUT[s] = round(2^FRAC_OUT*(log2(1+s/2^SEG_BITS) - s/2^SEG_BITS)), so LUT[0]=0 and exact powers of two are exact. y = (exp<<FRAC_OUT) + f + corr, signed, computed with one guard bit.
- S4: mode scaling.
  - mode 0: passes y through.
  - mode 1: computes (y*LN2_Q16 + 2^15) >>> 16 with LN2_Q16=45426.
  - mode 2: computes (y*LOG10_2_Q16 + 2^15) >>> 16 with LOG10_2_Q16=19728.
  - Arithmetic shift, round half-up.
  - Result saturates to OUT_WIDTH signed range.
- Zero operand: out_data = most-negative OUT_WIDTH value (0x8000 at defaults), out_zero=1, for all modes.
- Simultaneous accept and output handshake in the same cycle is legal; it sustains full rate.
- in_data/in_mode are ignored when not accepted.

Decomposition:
- Package `nlf_log_pkg`:
  - LN2_Q16 and LOG10_2_Q16 constants.
  - Mode enum (MODE_LOG2, MODE_LN, MODE_LOG10).
  - Function that builds the correction LUT as an elaboration-time constant from SEG_BITS/FRAC_OUT.
- One sub-module `lod_norm`: parametrised leading-one detector plus normaliser (combinational), instantiated between S1 and S2 registers.

Test Plan (defaults, FRAC_IN=FRAC_OUT=8, SEG_BITS=3):
- in_data=0x0100 (1.0), mode0 -> out_data=0x0000, out_zero=0, out_valid exactly 4 cycles after accept.
- in_data=0x0758 (7.34375), modes 0/1/2 back-to-back on consecutive cycles, out_ready=1 -> 0x02E5, 0x0202, 0x00DF on 3 consecutive cycles.
- in_data=0x0001 mode0 -> 0xF800 (-8.0); in_data=0x0400 mode0 -> 0x0200; in_data=0x0000 any mode -> 0x8000 with out_zero=1.
- Stream 8 beats, hold out_ready=0 for 5 cycles after first out_valid -> in_ready=0 during stall, out_data held stable, no beat lost or duplicated, order preserved.
- Assert rst=0 with 3 beats in flight -> out_valid drops asynchronously to 0; after release no stale result appears; next beat 0x0758 mode0 returns 0x02E5 after 4 cycles.
- Random in_data/mode/out_ready (10k beats) vs reference model of the same LUT/rounding rules -> bit-exact match.

Source files
------------

// File: rtl/nlf_log_pkg.sv
// Shared constants, mode encoding and the elaboration-time correction-LUT builder
// for the nonlinear-function log units.
package nlf_log_pkg;

  localparam int unsigned LN2_Q16     = 45426;
  localparam int unsigned LOG10_2_Q16 = 19728;

  // The LUT is returned at its largest supported size; callers index the first 2^seg_bits.
  localparam int unsigned CorrLutMax  = 256;
  localparam int unsigned CorrEntryW  = 16;
  localparam int unsigned LogFracBits = 24;

  typedef enum logic [1:0] {
    MODE_LOG2  = 2'd0,
    MODE_LN    = 2'd1,
    MODE_LOG10 = 2'd2
  } mode_e;

  typedef logic [CorrLutMax-1:0][CorrEntryW-1:0] corr_lut_t;

  // Entry s = round(2^frac_out * (log2(1 + s/2^seg_bits) - s/2^seg_bits)).
  // log2 of the mantissa is produced bit-serially by repeated squaring in Q30.
  function automatic corr_lut_t corr_lut(input int unsigned seg_bits,
                                         input int unsigned frac_out);
    logic [63:0] x;
    logic [63:0] lg;
    logic [63:0] diff;
    corr_lut = '0;
    for (int unsigned s = 0; s < CorrLutMax; s++) begin
      if (s < (32'd1 << seg_bits)) begin
        x  = ((64'd1 << seg_bits) + 64'(s)) << (30 - seg_bits);
        lg = '0;
        for (int unsigned b = 0; b < LogFracBits; b++) begin
          x  = (x * x) >> 30;
          lg = lg << 1;
          if (x >= (64'd1 << 31)) begin
            x  = x >> 1;
            lg = lg | 64'd1;
          end
        end
        diff = lg - (64'(s) << (LogFracBits - seg_bits));
        corr_lut[s] = CorrEntryW'((diff + (64'd1 << (LogFracBits - 1 - frac_out)))
                                  >> (LogFracBits - frac_out));
      end
    end
  endfunction

endpackage

// File: rtl/lod_norm.sv
// Leading-one detector plus normaliser: returns the leading-one position and the
// FRAC_OUT bits directly below it (zero-padded, truncated).
module lod_norm #(
  parameter int unsigned IN_WIDTH = 16,
  parameter int unsigned FRAC_OUT = 8,
  parameter int unsigned PW       = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1
) (
  input  logic [IN_WIDTH-1:0] data_i,
  output logic [PW-1:0]       pos_o,
  output logic [FRAC_OUT-1:0] frac_o
);

  localparam int unsigned ExtW = IN_WIDTH - 1 + FRAC_OUT;

  logic [PW-1:0]   shamt;
  logic [ExtW-1:0] ext;

  always_comb begin
    pos_o = '0;
    for (int i = 0; i < IN_WIDTH; i++) begin
      if (data_i[i]) begin
        pos_o = PW'(i);
      end
    end
  end

  // The leading one is shifted out past the top of ext, so it is dropped for free.
  always_comb begin
    shamt  = PW'(IN_WIDTH - 1) - pos_o;
    ext    = {data_i[IN_WIDTH-2:0], {FRAC_OUT{1'b0}}} << shamt;
    frac_o = FRAC_OUT'(ext >> (IN_WIDTH - 1));
  end

endmodule

// File: rtl/log2_pipe.sv
// Four-stage streaming fixed-point logarithm (log2 / ln / log10) using Mitchell's
// approximation with a segment-LUT correction; the whole pipe freezes under back-pressure.
module log2_pipe
  import nlf_log_pkg::*;
#(
  parameter int unsigned IN_WIDTH  = 16,
  parameter int unsigned FRAC_IN   = 8,
  parameter int unsigned OUT_WIDTH = 16,
  parameter int unsigned FRAC_OUT  = 8,
  parameter int unsigned SEG_BITS  = 3
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [IN_WIDTH-1:0]  in_data,
  input  logic [1:0]           in_mode,
  output logic                 out_valid,
  input  logic                 out_ready,
  output logic [OUT_WIDTH-1:0] out_data,
  output logic                 out_zero
);

  localparam int unsigned PW = (IN_WIDTH > 1) ? $clog2(IN_WIDTH) : 1;
  localparam int unsigned EW = PW + 2;
  localparam int unsigned YW = OUT_WIDTH + 1;

  localparam corr_lut_t CorrLut = corr_lut(SEG_BITS, FRAC_OUT);

  localparam longint OutMax    = (64'sd1 <<< (OUT_WIDTH - 1)) - 64'sd1;
  localparam longint OutMin    = -(64'sd1 <<< (OUT_WIDTH - 1));
  localparam longint RoundHalf = 64'sd1 <<< 15;
  localparam logic [OUT_WIDTH-1:0] MinOut = {1'b1, {(OUT_WIDTH - 1){1'b0}}};

  logic en;

  // S1: captured operand
  logic                s1_valid_q, s1_valid_d;
  logic [IN_WIDTH-1:0] s1_data_q, s1_data_d;
  logic                s1_zero_q, s1_zero_d;
  mode_e               s1_mode_q, s1_mode_d;

  // S2: exponent and normalised fraction
  logic                 s2_valid_q, s2_valid_d;
  logic signed [EW-1:0] s2_exp_q, s2_exp_d;
  logic [FRAC_OUT-1:0]  s2_frac_q, s2_frac_d;
  logic                 s2_zero_q, s2_zero_d;
  mode_e                s2_mode_q, s2_mode_d;

  // S3: corrected log2 with one guard bit
  logic                 s3_valid_q, s3_valid_d;
  logic signed [YW-1:0] s3_y_q, s3_y_d;
  logic                 s3_zero_q, s3_zero_d;
  mode_e                s3_mode_q, s3_mode_d;

  // S4: output register
  logic                 out_valid_q, out_valid_d;
  logic [OUT_WIDTH-1:0] out_data_q, out_data_d;
  logic                 out_zero_q, out_zero_d;

  logic [PW-1:0]       lod_pos;
  logic [FRAC_OUT-1:0] lod_frac;
  logic [SEG_BITS-1:0] seg;
  int                  y_full;
  longint              scaled;
  longint              clamped;

  assign en        = ~out_valid_q | out_ready;
  assign in_ready  = en;
  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign out_zero  = out_zero_q;

  lod_norm #(
    .IN_WIDTH (IN_WIDTH),
    .FRAC_OUT (FRAC_OUT),
    .PW       (PW)
  ) u_lod_norm (
    .data_i (s1_data_q),
    .pos_o  (lod_pos),
    .frac_o (lod_frac)
  );

  always_comb begin
    seg    = s2_frac_q[FRAC_OUT-1 -: SEG_BITS];
    y_full = (int'(s2_exp_q) <<< FRAC_OUT) + int'(s2_frac_q) + int'(CorrLut[seg]);
  end

  always_comb begin
    case (s3_mode_q)
      MODE_LN:    scaled = (longint'(s3_y_q) * longint'(LN2_Q16) + RoundHalf) >>> 16;
      MODE_LOG10: scaled = (longint'(s3_y_q) * longint'(LOG10_2_Q16) + RoundHalf) >>> 16;
      default:    scaled = longint'(s3_y_q);
    endcase
    if (scaled > OutMax) begin
      clamped = OutMax;
    end else if (scaled < OutMin) begin
      clamped = OutMin;
    end else begin
      clamped = scaled;
    end
  end

  always_comb begin
    s1_valid_d  = s1_valid_q;
    s1_data_d   = s1_data_q;
    s1_zero_d   = s1_zero_q;
    s1_mode_d   = s1_mode_q;
    s2_valid_d  = s2_valid_q;
    s2_exp_d    = s2_exp_q;
    s2_frac_d   = s2_frac_q;
    s2_zero_d   = s2_zero_q;
    s2_mode_d   = s2_mode_q;
    s3_valid_d  = s3_valid_q;
    s3_y_d      = s3_y_q;
    s3_zero_d   = s3_zero_q;
    s3_mode_d   = s3_mode_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    out_zero_d  = out_zero_q;

    if (en) begin
      s1_valid_d = in_valid;
      if (in_valid) begin
        s1_data_d = in_data;
        s1_zero_d = (in_data == '0);
        // Reserved mode 3 behaves as plain log2.
        s1_mode_d = (in_mode == 2'd3) ? MODE_LOG2 : mode_e'(in_mode);
      end

      s2_valid_d = s1_valid_q;
      s2_exp_d   = $signed(EW'(lod_pos)) - $signed(EW'(FRAC_IN));
      s2_frac_d  = lod_frac;
      s2_zero_d  = s1_zero_q;
      s2_mode_d  = s1_mode_q;

      s3_valid_d = s2_valid_q;
      s3_y_d     = YW'(y_full);
      s3_zero_d  = s2_zero_q;
      s3_mode_d  = s2_mode_q;

      out_valid_d = s3_valid_q;
      out_data_d  = s3_zero_q ? MinOut : OUT_WIDTH'(clamped);
      out_zero_d  = s3_zero_q;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      s1_valid_q  <= 1'b0;
      s1_data_q   <= '0;
      s1_zero_q   <= 1'b0;
      s1_mode_q   <= MODE_LOG2;
      s2_valid_q  <= 1'b0;
      s2_exp_q    <= '0;
      s2_frac_q   <= '0;
      s2_zero_q   <= 1'b0;
      s2_mode_q   <= MODE_LOG2;
      s3_valid_q  <= 1'b0;
      s3_y_q      <= '0;
      s3_zero_q   <= 1'b0;
      s3_mode_q   <= MODE_LOG2;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      out_zero_q  <= 1'b0;
    end else begin
      s1_valid_q  <= s1_valid_d;
      s1_data_q   <= s1_data_d;
      s1_zero_q   <= s1_zero_d;
      s1_mode_q   <= s1_mode_d;
      s2_valid_q  <= s2_valid_d;
      s2_exp_q    <= s2_exp_d;
      s2_frac_q   <= s2_frac_d;
      s2_zero_q   <= s2_zero_d;
      s2_mode_q   <= s2_mode_d;
      s3_valid_q  <= s3_valid_d;
      s3_y_q      <= s3_y_d;
      s3_zero_q   <= s3_zero_d;
      s3_mode_q   <= s3_mode_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      out_zero_q  <= out_zero_d;
    end
  end

endmodule

// File: tb/tb_log2_pipe.sv
// Scoreboard bench for log2_pipe: directed vectors, back-pressure, mid-flight reset and
// random traffic against a real-arithmetic reference model.
module tb_log2_pipe;

  localparam int unsigned IW = 16;
  localparam int unsigned FI = 8;
  localparam int unsigned OW = 16;
  localparam int unsigned FO = 8;
  localparam int unsigned SB = 3;
  localparam int NRand = 10000;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          in_valid = 1'b0;
  logic          in_ready;
  logic [IW-1:0] in_data = '0;
  logic [1:0]    in_mode = '0;
  logic          out_valid;
  logic          out_ready = 1'b1;
  logic [OW-1:0] out_data;
  logic          out_zero;

  always #5 clk = ~clk;

  log2_pipe #(
    .IN_WIDTH  (IW),
    .FRAC_IN   (FI),
    .OUT_WIDTH (OW),
    .FRAC_OUT  (FO),
    .SEG_BITS  (SB)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_mode   (in_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_zero  (out_zero)
  );

  typedef struct {
    logic [OW-1:0] data;
    logic          zero;
    int            acc_cyc;
    int            acc_stall;
  } exp_t;

  exp_t sb_q[$];
  int   n_cmp = 0;
  int   n_bad = 0;
  int   cyc = 0;
  int   stalls = 0;
  int   rdy_pol = 0;
  int   win_lo = 0;
  int   win_hi = 0;
  int   lut [1 << SB];

  always @(posedge clk) cyc <= cyc + 1;

  function automatic void check(input string name, input longint act, input longint req);
    n_cmp++;
    if (act != req) begin
      n_bad++;
      $display("FAIL %s: got 0x%0h, want 0x%0h (cycle %0d)", name, act, req, cyc);
    end
  endfunction

  // Reference: log2(x) = p + log2(1+m), m approximated by the truncated fraction plus table.
  function automatic exp_t model(input logic [IW-1:0] d, input logic [1:0] m);
    exp_t   e;
    longint p, f, y;
    e.acc_cyc   = 0;
    e.acc_stall = 0;
    if (d == '0) begin
      e.zero = 1'b1;
      e.data = {1'b1, {(OW - 1){1'b0}}};
      return e;
    end
    p = 0;
    while ((longint'(1) << (p + 1)) <= longint'(d)) p++;
    f = ((longint'(d) << FO) >> p) - (longint'(1) << FO);
    y = (p - FI) * (longint'(1) << FO) + f + lut[f >> (FO - SB)];
    if (m == 2'd1) y = (y * 45426 + 32768) >>> 16;
    else if (m == 2'd2) y = (y * 19728 + 32768) >>> 16;
    if (y > 32767) y = 32767;
    if (y < -32768) y = -32768;
    e.zero = 1'b0;
    e.data = OW'(y);
    return e;
  endfunction

  task automatic set_ready();
    case (rdy_pol)
      1:       out_ready = ($urandom_range(3) != 0);
      2:       out_ready = !(cyc >= win_lo && cyc < win_hi);
      default: out_ready = 1'b1;
    endcase
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(negedge clk);
      in_valid = 1'b0;
      in_data  = IW'($urandom);
      in_mode  = 2'($urandom_range(3));
      set_ready();
    end
  endtask

  task automatic send(input logic [IW-1:0] d, input logic [1:0] m,
                      input logic [OW-1:0] ed, input logic ez);
    exp_t e;
    int   tries;
    tries = 0;
    forever begin
      @(negedge clk);
      in_valid = 1'b1;
      in_data  = d;
      in_mode  = m;
      set_ready();
      #1;
      if (in_ready) begin
        e.data      = ed;
        e.zero      = ez;
        e.acc_cyc   = cyc;
        e.acc_stall = stalls;
        sb_q.push_back(e);
        break;
      end
      tries++;
      if (tries > 2000) begin
        check("accept_timeout", in_ready, 1);
        break;
      end
    end
  endtask

  task automatic send_model(input logic [IW-1:0] d, input logic [1:0] m);
    exp_t e;
    e = model(d, m);
    send(d, m, e.data, e.zero);
  endtask

  // Monitor: samples mid-cycle, the handshake completes at the following rising edge.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst) begin
        if (out_valid) begin
          if (sb_q.size() == 0) begin
            check("spurious_out_valid", out_valid, 0);
          end else if (out_ready) begin
            e = sb_q.pop_front();
            check("out_data", out_data, e.data);
            check("out_zero", out_zero, e.zero);
            check("latency", cyc - e.acc_cyc, 4 + stalls - e.acc_stall);
            check("in_ready_flow", in_ready, 1);
          end else begin
            check("stall_hold_data", out_data, sb_q[0].data);
            check("stall_hold_zero", out_zero, sb_q[0].zero);
            check("stall_in_ready", in_ready, 0);
            stalls++;
          end
        end else begin
          check("idle_in_ready", in_ready, 1);
        end
      end
    end
  end

  initial begin
    logic [IW-1:0] d;
    int            w;
    for (int s = 0; s < (1 << SB); s++) begin
      real r;
      r = real'(s) / (2.0 ** SB);
      lut[s] = $rtoi((2.0 ** FO) * ($ln(1.0 + r) / $ln(2.0) - r) + 0.5);
    end

    repeat (3) @(negedge clk);
    check("reset_out_valid", out_valid, 0);
    check("reset_out_data", out_data, 0);
    check("reset_out_zero", out_zero, 0);
    check("reset_in_ready", in_ready, 1);
    rst = 1'b1;

    // Directed vectors, out_ready held high
    rdy_pol = 0;
    send(16'h0100, 2'd0, 16'h0000, 1'b0);
    idle(6);
    send(16'h0758, 2'd0, 16'h02E5, 1'b0);
    send(16'h0758, 2'd1, 16'h0202, 1'b0);
    send(16'h0758, 2'd2, 16'h00DF, 1'b0);
    send(16'h0001, 2'd0, 16'hF800, 1'b0);
    send(16'h0400, 2'd0, 16'h0200, 1'b0);
    send(16'hFFFF, 2'd0, 16'h0807, 1'b0);
    send(16'hFFFF, 2'd1, 16'h0590, 1'b0);
    for (int m = 0; m < 4; m++) send(16'h0000, 2'(m), 16'h8000, 1'b1);
    idle(8);

    // Back-pressure: 5 stalled cycles starting at the first result
    win_lo  = cyc + 1 + 4;
    win_hi  = win_lo + 5;
    rdy_pol = 2;
    for (int i = 0; i < 8; i++) send_model(IW'(16'h0100 + i * 16'h0133), 2'(i % 4));
    idle(20);
    rdy_pol = 0;

    // Reset with one result presented and three beats in flight
    for (int i = 0; i < 5; i++) send_model(IW'(16'h0200 + i * 16'h0111), 2'd0);
    @(negedge clk);
    in_valid = 1'b0;
    #3;
    rst = 1'b0;
    #1;
    check("async_rst_out_valid", out_valid, 0);
    check("async_rst_out_data", out_data, 0);
    check("async_rst_out_zero", out_zero, 0);
    sb_q.delete();
    @(negedge clk);
    rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      idle(1);
      #1;
      check("post_rst_no_stale", out_valid, 0);
    end
    send(16'h0758, 2'd0, 16'h02E5, 1'b0);
    idle(6);

    // Random traffic with random back-pressure
    rdy_pol = 1;
    for (int i = 0; i < NRand; i++) begin
      if ($urandom_range(3) == 0) idle(1);
      w = $urandom_range(19);
      if (w == 0) d = '0;
      else if (w < 5) d = IW'($urandom_range(15, 1));
      else d = IW'($urandom);
      send_model(d, 2'($urandom_range(3)));
    end

    rdy_pol = 0;
    w = 0;
    while (sb_q.size() != 0 && w < 500) begin
      idle(1);
      w++;
    end
    check("drain_empty", sb_q.size(), 0);
    #5;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
